// File: rtl/nocif_dram_read_eg_rtn.sv
`default_nettype none
// ============================================================================
// Module   : nocif_dram_read_eg_rtn
// Brief    : NOCIF DRAM read-egress return router. Demultiplexes ID-tagged
//            response beats into per-client return FIFOs and tracks
//            per-client outstanding beats posted by the read-ingress side.
// Option   : NVDLA_RD_EG_PERF_EN enables the eg_stall_cnt performance counter
//            (undefined: eg_stall_cnt is tied to zero).
// Revision : 1.0 - initial release
// ============================================================================
module nocif_dram_read_eg_rtn #(
    parameter int NUM_CLIENTS = 10,
    parameter int DATA_W      = 514,
    parameter int ID_W        = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 10
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rstn,
    input  logic                          noc2eg_rsp_valid,
    output logic                          noc2eg_rsp_ready,
    input  logic [ID_W-1:0]               noc2eg_rsp_id,
    input  logic [DATA_W-1:0]             noc2eg_rsp_pd,
    input  logic                          ig2eg_req_valid,
    input  logic [ID_W-1:0]               ig2eg_req_client,
    input  logic [2:0]                    ig2eg_req_beats,
    output logic [NUM_CLIENTS-1:0]        eg2client_rsp_valid,
    input  logic [NUM_CLIENTS-1:0]        eg2client_rsp_ready,
    output logic [NUM_CLIENTS*DATA_W-1:0] eg2client_rsp_pd,
    output logic [NUM_CLIENTS-1:0]        eg2ig_client_idle,
    output logic [1:0]                    eg_err,
    output logic [31:0]                   eg_stall_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [PW-1:0]          wr_ptr_q [NUM_CLIENTS];
    logic [PW-1:0]          rd_ptr_q [NUM_CLIENTS];
    logic [CNT_W-1:0]       cnt_q    [NUM_CLIENTS];
    logic [CNT_W-1:0]       cnt_d    [NUM_CLIENTS];
    logic [CNT_W:0]         sum_w    [NUM_CLIENTS];
    logic [CNT_W:0]         diff_w   [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] full_w;
    logic [NUM_CLIENTS-1:0] empty_w;
    logic [NUM_CLIENTS-1:0] push_w;
    logic [NUM_CLIENTS-1:0] pop_w;
    logic [NUM_CLIENTS-1:0] inc_w;
    logic [NUM_CLIENTS-1:0] idle_q;
    logic [1:0]             err_q;
    logic                   rsp_bad_w;
    logic                   req_bad_w;
    logic                   rsp_acc_w;
    logic                   cnt_err_w;

    assign rsp_bad_w = int'(noc2eg_rsp_id)    >= NUM_CLIENTS;
    assign req_bad_w = int'(ig2eg_req_client) >= NUM_CLIENTS;
    assign rsp_acc_w = noc2eg_rsp_valid && noc2eg_rsp_ready;

    // Input ready follows the addressed FIFO's full flag (from flops only); bad IDs are sunk
    always_comb begin
        noc2eg_rsp_ready = 1'b1;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (noc2eg_rsp_id == ID_W'(i)) begin
                noc2eg_rsp_ready = !full_w[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
        logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

        assign empty_w[gi] = (wr_ptr_q[gi] == rd_ptr_q[gi]);
        assign full_w[gi]  = (wr_ptr_q[gi][AW] != rd_ptr_q[gi][AW]) &&
                             (wr_ptr_q[gi][AW-1:0] == rd_ptr_q[gi][AW-1:0]);
        assign push_w[gi]  = rsp_acc_w && !rsp_bad_w && (noc2eg_rsp_id == ID_W'(gi));
        assign pop_w[gi]   = !empty_w[gi] && eg2client_rsp_ready[gi];
        assign inc_w[gi]   = ig2eg_req_valid && !req_bad_w && (ig2eg_req_client == ID_W'(gi));

        assign eg2client_rsp_valid[gi]               = !empty_w[gi];
        assign eg2client_rsp_pd[gi*DATA_W +: DATA_W] = mem_q[rd_ptr_q[gi][AW-1:0]];

        // Payload storage, written on push; intentionally not reset
        always_ff @(posedge nvdla_core_clk) begin
            if (push_w[gi]) begin
                mem_q[wr_ptr_q[gi][AW-1:0]] <= noc2eg_rsp_pd;
            end
        end
    end

    // Net counter update: add posted beats, subtract a pop, saturate or hold at zero on error
    always_comb begin
        cnt_err_w = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            sum_w[i]  = {1'b0, cnt_q[i]} +
                        (inc_w[i] ? ((CNT_W+1)'(ig2eg_req_beats) + (CNT_W+1)'(1)) : '0);
            diff_w[i] = sum_w[i] - (CNT_W+1)'(pop_w[i]);
            cnt_d[i]  = diff_w[i][CNT_W-1:0];
            if (pop_w[i] && (sum_w[i] == '0)) begin
                cnt_d[i]  = '0;
                cnt_err_w = 1'b1;
            end else if (diff_w[i] > CNT_MAX) begin
                cnt_d[i]  = '1;
                cnt_err_w = 1'b1;
            end
        end
    end

    // FIFO pointers, outstanding counters, idle flags and sticky errors
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            idle_q <= '1;
            err_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (push_w[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                end
                if (pop_w[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                end
                cnt_q[i]  <= cnt_d[i];
                idle_q[i] <= (cnt_q[i] == '0) && empty_w[i];
            end
            if ((rsp_acc_w && rsp_bad_w) || (ig2eg_req_valid && req_bad_w)) begin
                err_q[0] <= 1'b1;
            end
            if (cnt_err_w) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign eg2ig_client_idle = idle_q;
    assign eg_err            = err_q;

`ifdef NVDLA_RD_EG_PERF_EN
    logic [31:0] stall_cnt_q;

    // Count cycles where a presented beat is held off; saturating
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt_q <= '0;
        end else if (noc2eg_rsp_valid && !noc2eg_rsp_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign eg_stall_cnt = stall_cnt_q;
`else
    assign eg_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nocif_dram_read_eg_rtn.sv
`default_nettype none
// ============================================================================
// Module   : tb_nocif_dram_read_eg_rtn
// Brief    : Directed self-checking bench for nocif_dram_read_eg_rtn.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nocif_dram_read_eg_rtn;

    localparam int NC = 10;
    localparam int DW = 514;
    localparam int IW = 4;

`ifdef NVDLA_RD_EG_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_pd;
    logic              req_valid;
    logic [IW-1:0]     req_client;
    logic [2:0]        req_beats;
    logic [NC-1:0]     cl_valid;
    logic [NC-1:0]     cl_ready;
    logic [NC*DW-1:0]  cl_pd;
    logic [NC-1:0]     idle;
    logic [1:0]        err;
    logic [31:0]       stall;

    int n_tests = 0;
    int n_fail  = 0;

    nocif_dram_read_eg_rtn dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .noc2eg_rsp_valid    (rsp_valid),
        .noc2eg_rsp_ready    (rsp_ready),
        .noc2eg_rsp_id       (rsp_id),
        .noc2eg_rsp_pd       (rsp_pd),
        .ig2eg_req_valid     (req_valid),
        .ig2eg_req_client    (req_client),
        .ig2eg_req_beats     (req_beats),
        .eg2client_rsp_valid (cl_valid),
        .eg2client_rsp_ready (cl_ready),
        .eg2client_rsp_pd    (cl_pd),
        .eg2ig_client_idle   (idle),
        .eg_err              (err),
        .eg_stall_cnt        (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pd_of(input int c);
        return cl_pd[c*DW +: DW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; rsp_valid = 1'b0; rsp_id = '0; rsp_pd = '0;
        req_valid = 1'b0; req_client = '0; req_beats = '0; cl_ready = '0;
        tick(); tick();
        rstn = 1'b1;
        #1;
        chk("rst_ready", rsp_ready, 1);
        chk("rst_valid", cl_valid, 0);
        chk("rst_idle",  idle, 10'h3FF);
        chk("rst_err",   err, 0);
        chk("rst_stall", stall, 0);

        // 1: single beat routing to client 3
        tick();
        req_valid = 1'b1; req_client = 4'd3; req_beats = 3'd0;
        tick();
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_id = 4'd3; rsp_pd = 'h1A5;
        #1;
        chk("t1_ready", rsp_ready, 1);
        chk("t1_no_bypass", cl_valid[3], 0);
        tick();
        rsp_valid = 1'b0;
        chk("t1_valid", cl_valid, 10'h008);
        chk("t1_pd", pd_of(3), 'h1A5);
        chk("t1_busy", idle[3], 0);
        cl_ready[3] = 1'b1;
        tick();
        cl_ready[3] = 1'b0;
        chk("t1_popped", cl_valid[3], 0);
        tick();
        chk("t1_idle", idle[3], 1);
        chk("t1_err", err, 0);

        // 2: FIFO full and head-of-line blocking on client 2
        req_valid = 1'b1; req_client = 4'd2; req_beats = 3'd4;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rsp_valid = 1'b1; rsp_id = 4'd2; rsp_pd = DW'(32'h200 + k);
            #1;
            chk($sformatf("t2_ready_%0d", k), rsp_ready, (k < 4) ? 1 : 0);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t2_block_%0d", j), rsp_ready, 0);
            chk("t2_no_c5", cl_valid[5], 0);
            tick();
        end
        chk("t2_stall", stall, (PERF != 0) ? 4 : 0);
        cl_ready[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t2_valid_%0d", c), cl_valid[2], 1);
            chk($sformatf("t2_pd_%0d", c), pd_of(2), DW'(32'h200 + c));
            if (c == 1) chk("t2_reopen", rsp_ready, 1);
            tick();
            if (c == 1) rsp_valid = 1'b0;
        end
        chk("t2_drained", cl_valid[2], 0);
        cl_ready[2] = 1'b0;
        tick();
        chk("t2_idle", idle[2], 1);
        chk("t2_err", err, 0);

        // 3: same-cycle push, pop and request on client 0
        req_valid = 1'b1; req_client = 4'd0; req_beats = 3'd0;
        tick();
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_id = 4'd0; rsp_pd = 'h300;
        tick();
        chk("t3_cnt_pre", dut.cnt_q[0], 1);
        rsp_pd = 'h301; cl_ready[0] = 1'b1;
        req_valid = 1'b1; req_client = 4'd0; req_beats = 3'd3;
        tick();
        rsp_valid = 1'b0; req_valid = 1'b0;
        chk("t3_cnt", dut.cnt_q[0], 4);
        chk("t3_valid", cl_valid[0], 1);
        chk("t3_pd", pd_of(0), 'h301);
        tick();
        cl_ready[0] = 1'b0;
        chk("t3_occ1", cl_valid[0], 0);
        chk("t3_err", err, 0);

        // 4: bad response ID is sunk and flagged
        rsp_valid = 1'b1; rsp_id = 4'd12; rsp_pd = 'h4AA;
        #1;
        chk("t4_ready", rsp_ready, 1);
        tick();
        rsp_valid = 1'b0;
        chk("t4_valid", cl_valid, 0);
        chk("t4_err", err, 2'b01);
        tick(); tick();
        chk("t4_sticky", err, 2'b01);

        // 5: pop on client 7 with zero outstanding
        rsp_valid = 1'b1; rsp_id = 4'd7; rsp_pd = 'h777;
        tick();
        rsp_valid = 1'b0;
        chk("t5_valid", cl_valid[7], 1);
        chk("t5_pd", pd_of(7), 'h777);
        cl_ready[7] = 1'b1;
        tick();
        cl_ready[7] = 1'b0;
        chk("t5_popped", cl_valid[7], 0);
        chk("t5_err", err, 2'b11);
        chk("t5_cnt", dut.cnt_q[7], 0);

        // 6: reset with three FIFOs occupied
        for (int k = 0; k < 3; k++) begin
            rsp_valid = 1'b1; rsp_id = (k == 0) ? 4'd1 : (k == 1) ? 4'd4 : 4'd6;
            rsp_pd = DW'(32'h600 + k);
            tick();
        end
        rsp_valid = 1'b0;
        chk("t6_fill", cl_valid, 10'h052);
        rstn = 1'b0;
        #1;
        chk("t6_async_valid", cl_valid, 0);
        tick(); tick();
        rstn = 1'b1;
        #1;
        chk("t6_idle", idle, 10'h3FF);
        chk("t6_err", err, 0);
        tick();
        chk("t6_idle_hold", idle, 10'h3FF);
        chk("t6_cnt4", dut.cnt_q[4], 0);
        req_valid = 1'b1; req_client = 4'd9; req_beats = 3'd0;
        tick();
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_id = 4'd9; rsp_pd = 'h999;
        #1;
        chk("t6_ready", rsp_ready, 1);
        tick();
        rsp_valid = 1'b0;
        chk("t6_valid", cl_valid, 10'h200);
        chk("t6_pd", pd_of(9), 'h999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
